// File: rtl/fetch_stage_ctrl.sv
// rtl/fetch_stage_ctrl.sv - PC, IF/ID register and instruction-memory request control
//
// Purpose: owns the fetch PC and IF/ID pipeline register, issues instruction
// memory reads, inserts bubbles on stalls/misses/flushes, and keeps a returned
// instruction in a skid register while decode is stalled.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   PC_Write_Enable_in       hazard unit: PC may advance
//   IF_ID_WriteEnable_in     hazard unit: IF/ID may load
//   branch_taken_in          redirect/flush request (one cycle per redirect)
//   branch_target_in         redirect target
//   halt_in                  HALT decoded in ID
//   imem_rdata_in            instruction data, valid with imem_done_in
//   imem_done_in             request complete
//   imem_addr_out            fetch address (= PC_out)
//   imem_rd_out              read request level
//   PC_out                   current fetch PC
//   IF_ID_instr_out          instruction to decode
//   IF_ID_PCplus2_out        PC+2 of that instruction
//   IF_ID_valid_out          1 = real instruction, 0 = bubble
module fetch_stage_ctrl #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PC_Write_Enable_in,
  input  logic        IF_ID_WriteEnable_in,
  input  logic        branch_taken_in,
  input  logic [15:0] branch_target_in,
  input  logic        halt_in,
  input  logic [15:0] imem_rdata_in,
  input  logic        imem_done_in,
  output logic [15:0] imem_addr_out,
  output logic        imem_rd_out,
  output logic [15:0] PC_out,
  output logic [15:0] IF_ID_instr_out,
  output logic [15:0] IF_ID_PCplus2_out,
  output logic        IF_ID_valid_out
);

  typedef enum logic [1:0] {FETCH, HOLD, HALTED} state_t;

  state_t      state, state_n;
  logic [15:0] pc, pc_n;
  logic [15:0] ifid_instr, ifid_instr_n;
  logic [15:0] ifid_pc2, ifid_pc2_n;
  logic        ifid_valid, ifid_valid_n;
  logic [15:0] skid, skid_n;
  logic        squash_pend, squash_pend_n;
  logic [15:0] target_pend, target_pend_n;
  logic        halt_pend, halt_pend_n;
  // Cleared by reset so no request is raised in the cycle rst deasserts;
  // keeps imem_rd_out purely registered.
  logic        started;

  logic        advance;
  logic        req;
  logic        done;
  logic        halt_req;
  logic [15:0] pc_plus2;

  assign advance  = PC_Write_Enable_in & IF_ID_WriteEnable_in;
  assign req      = (state == FETCH) & started;
  assign done     = req & imem_done_in;
  assign halt_req = halt_in & ~branch_taken_in;
  assign pc_plus2 = pc + 16'd2;

  assign imem_rd_out       = req;
  assign imem_addr_out     = pc;
  assign PC_out            = pc;
  assign IF_ID_instr_out   = ifid_instr;
  assign IF_ID_PCplus2_out = ifid_pc2;
  assign IF_ID_valid_out   = ifid_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      ifid_instr  <= NOP_INSTR;
      ifid_pc2    <= 16'h0000;
      ifid_valid  <= 1'b0;
      skid        <= 16'h0000;
      squash_pend <= 1'b0;
      target_pend <= 16'h0000;
      halt_pend   <= 1'b0;
      started     <= 1'b0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      ifid_instr  <= ifid_instr_n;
      ifid_pc2    <= ifid_pc2_n;
      ifid_valid  <= ifid_valid_n;
      skid        <= skid_n;
      squash_pend <= squash_pend_n;
      target_pend <= target_pend_n;
      halt_pend   <= halt_pend_n;
      started     <= 1'b1;
    end
  end

  always_comb begin
    state_n       = state;
    pc_n          = pc;
    ifid_instr_n  = ifid_instr;
    ifid_pc2_n    = ifid_pc2;
    ifid_valid_n  = ifid_valid;
    skid_n        = skid;
    squash_pend_n = squash_pend;
    target_pend_n = target_pend;
    halt_pend_n   = halt_pend;

    // Bubble on advance unless a real instruction is loaded below.
    if (advance || branch_taken_in) begin
      ifid_instr_n = NOP_INSTR;
      ifid_valid_n = 1'b0;
    end

    case (state)
      FETCH: begin
        if (branch_taken_in) begin
          // The redirecting branch is older than anything in ID, so a
          // pending halt belongs to a squashed instruction.
          halt_pend_n = 1'b0;
          if (done || !req) begin
            pc_n          = branch_target_in;
            squash_pend_n = 1'b0;
          end else begin
            squash_pend_n = 1'b1;
            target_pend_n = branch_target_in;
          end
        end else if (done) begin
          if (halt_pend || halt_req) begin
            state_n     = HALTED;
            halt_pend_n = 1'b0;
          end else if (squash_pend) begin
            pc_n          = target_pend;
            squash_pend_n = 1'b0;
          end else if (advance) begin
            ifid_instr_n = imem_rdata_in;
            ifid_pc2_n   = pc_plus2;
            ifid_valid_n = 1'b1;
            pc_n         = pc_plus2;
          end else begin
            skid_n  = imem_rdata_in;
            state_n = HOLD;
          end
        end else if (halt_req) begin
          halt_pend_n = 1'b1;
        end
      end

      HOLD: begin
        if (branch_taken_in) begin
          halt_pend_n = 1'b0;
          skid_n      = 16'h0000;
          pc_n        = branch_target_in;
          state_n     = FETCH;
        end else if (halt_req || halt_pend) begin
          halt_pend_n = 1'b0;
          skid_n      = 16'h0000;
          state_n     = HALTED;
        end else if (advance) begin
          ifid_instr_n = skid;
          ifid_pc2_n   = pc_plus2;
          ifid_valid_n = 1'b1;
          pc_n         = pc_plus2;
          state_n      = FETCH;
        end
      end

      HALTED: begin
        // Frozen until reset; only bubbles reach IF/ID.
      end

      default: state_n = FETCH;
    endcase
  end

endmodule
